seq_multiplier_param: RTL and testbench
=======================================

// Module: seq_multiplier_param
// PURPOSE
//  Parametrised sequential shift-add multiplier: controller, counter and datapath in one block.
//  Processes one multiplier bit per cycle.
//  Supports signed (two's complement) and unsigned operands, selected per transaction.
//  valid/ready handshake on the input side and on the output side.
//  Sits between an operand producer and a result consumer; replaces fixed-width multiplier instances.
// PARAMETERS
//  WIDTH  16  operand width in bits (>=2); product width is 2*WIDTH
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        asynchronous, active-low reset
//  valid_in      in   1        operands and mode valid
//  ready_in      out  1        block can accept operands
//  multiplicand  in   WIDTH    operand A
//  multiplier    in   WIDTH    operand B, consumed LSB first
//  signed_mode   in   1        1: A and B are two's complement; 0: unsigned
//  product       out  2*WIDTH  result, valid when valid_out=1
//  valid_out     out  1        product valid
//  ready_out     in   1        consumer accepts product
//  busy          out  1        high in CALC or DONE
// BEHAVIOUR
//  Reset (rst low, async): state=IDLE, product=0, valid_out=0, busy=0, counter=0.
//   ready_in=1 as soon as rst is released.
//  States:
//   IDLE: ready_in=1. On valid_in && ready_in, go to CALC.
//    At that edge: latch A, B and mode; clear the accumulator; clear the counter.
//   CALC: ready_in=0, busy=1. Each cycle, if the current B bit is 1, add A (sign-extended in signed mode) into the accumulator.
//    In signed mode the MSB cycle subtracts instead of adding.
//    Shift right one bit (arithmetic shift in signed mode); increment the counter.
//    After bit WIDTH-1 is processed, go to DONE.
//   DONE: valid_out=1 and product is held stable.
//    On ready_out=1, return to IDLE; valid_out=0 on the next cycle.
//  No WAIT bypass: the result is always registered; valid_out never rises in the same cycle as the last add.
//  Latency: accept at edge k -> valid_out=1 from edge k+WIDTH (no early termination).
//  Throughput: 1 result per WIDTH+2 cycles with ready_out tied high.
//  Widths: accumulator is 2*WIDTH+1 bits internally; product = low 2*WIDTH bits (exact, never overflows).
//  Boundary conditions:
//   valid_in while not IDLE: ignored; ready_in=0, so operands are not consumed.
//   ready_out high before DONE: no effect.
//   valid_out, once high, stays high until ready_out (AXI-style, no retraction).
//   A or B = 0: the full WIDTH cycles still run; product=0.
//   Signed most-negative operands: -2^(W-1) * -2^(W-1) = 2^(2W-2), exact.
//   Reset mid-CALC or mid-DONE: the transaction is abandoned; all outputs take reset values immediately; no partial product is emitted.
//   signed_mode is sampled only at accept; later changes are ignored.
// CONFIGURATION
//  SEQ_MUL_EARLY_TERM_EN defined:
//   In CALC, if all remaining unprocessed B bits (including the MSB) are 0, go to DONE on that edge.
//   The product is identical to the full run.
//   Latency = max(1, index of highest set B bit + 1) cycles in CALC.
//   A negative B in signed mode always runs WIDTH cycles.
//  SEQ_MUL_EARLY_TERM_EN not defined: CALC always runs exactly WIDTH cycles.
// TESTING (WIDTH=8, ready_out=1 unless stated)
//  1. Unsigned 255*255 -> product=16'hFE01.
//     valid_out rises 8 cycles after accept; held 1 cycle; ready_in=1 the cycle after.
//  2. Signed -3*5 -> 16'hFFF1. Signed -128*-128 -> 16'h4000. Signed 127*-128 -> 16'hC080.
//  3. Backpressure: 12*10, ready_out=0 for 5 cycles after valid_out rises.
//     -> product=16'h0078 stable; valid_out=1 throughout; ready_in=0; new valid_in ignored.
//  4. Reset mid-CALC: assert rst at cycle 3 of 200*3.
//     -> valid_out=0, product=0, ready_in=1 after release.
//     -> The next transaction, 7*9, gives 16'h003F.
//  5. Back-to-back: valid_in held high with 2*3 then 4*5.
//     -> results 6 then 20 in order; second accept only in IDLE.
//  6. With SEQ_MUL_EARLY_TERM_EN: unsigned 100*1 -> 16'h0064 after 1 CALC cycle.
//     Signed 5*-1 -> 16'hFFFB after 8 CALC cycles.

Source files
------------

// File: rtl/seq_multiplier_param_if.sv
// Operand/result handshake bundle for seq_multiplier_param.
// The master drives operands and accepts results; the slave is the multiplier.
interface seq_multiplier_param_if #(
  parameter int WIDTH = 16
);
  logic                   valid_in;
  logic                   ready_in;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   signed_mode;
  logic [2*WIDTH-1:0]     product;
  logic                   valid_out;
  logic                   ready_out;
  logic                   busy;

  modport master (
    output valid_in, multiplicand, multiplier, signed_mode, ready_out,
    input  ready_in, product, valid_out, busy
  );

  modport slave (
    input  valid_in, multiplicand, multiplier, signed_mode, ready_out,
    output ready_in, product, valid_out, busy
  );
endinterface

// File: rtl/seq_multiplier_param.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, signed/unsigned per transaction.
// Optional SEQ_MUL_EARLY_TERM_EN: leave CALC once all remaining multiplier bits are zero.
module seq_multiplier_param #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_multiplier_param_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic                 mode_reg;
  logic [CW-1:0]        cnt_reg;
  logic [2*WIDTH:0]     acc_reg;
  logic [2*WIDTH-1:0]   product_reg;
  logic                 valid_out_reg;
  logic                 ready_in_reg;
  logic                 busy_reg;

  logic [WIDTH:0]       a_ext;
  logic [WIDTH:0]       hi;
  logic [WIDTH:0]       sum;
  logic                 fill;
  logic [2*WIDTH:0]     acc_next;
  logic                 last_bit;
  logic [2*WIDTH-1:0]   product_next;
`ifdef SEQ_MUL_EARLY_TERM_EN
  logic [CW-1:0]        rem;
`endif

  // Upper WIDTH+1 bits hold the running partial sum; the low half collects
  // product bits as they are shifted out of the adder.
  always_comb begin
    a_ext = mode_reg ? {a_reg[WIDTH-1], a_reg} : {1'b0, a_reg};
    hi    = acc_reg[2*WIDTH:WIDTH];
    sum   = hi;
    if (b_reg[0]) begin
      // Two's complement: the MSB of B carries weight -2^(WIDTH-1).
      if (mode_reg && (cnt_reg == LAST)) begin
        sum = hi - a_ext;
      end else begin
        sum = hi + a_ext;
      end
    end
    fill     = mode_reg & sum[WIDTH];
    acc_next = (2*WIDTH+1)'({fill, sum, acc_reg[WIDTH-1:0]} >> 1);
`ifdef SEQ_MUL_EARLY_TERM_EN
    // Skipped iterations would only shift, so apply the remaining shifts at once.
    rem      = LAST - cnt_reg;
    last_bit = (cnt_reg == LAST) || (b_reg[WIDTH-1:1] == '0);
    if (mode_reg) begin
      product_next = (2*WIDTH)'($signed(acc_next) >>> rem);
    end else begin
      product_next = (2*WIDTH)'(acc_next >> rem);
    end
`else
    last_bit     = (cnt_reg == LAST);
    product_next = acc_next[2*WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      mode_reg      <= 1'b0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      product_reg   <= '0;
      valid_out_reg <= 1'b0;
      ready_in_reg  <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.valid_in && ready_in_reg) begin
            a_reg        <= bus.multiplicand;
            b_reg        <= bus.multiplier;
            mode_reg     <= bus.signed_mode;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            ready_in_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= CALC;
          end
        end
        CALC: begin
          acc_reg <= acc_next;
          b_reg   <= b_reg >> 1;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_bit) begin
            product_reg   <= product_next;
            valid_out_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          // Product stays frozen until the consumer takes it.
          if (bus.ready_out) begin
            valid_out_reg <= 1'b0;
            busy_reg      <= 1'b0;
            ready_in_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          valid_out_reg <= 1'b0;
          busy_reg      <= 1'b0;
          ready_in_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_in  = ready_in_reg;
  assign bus.product   = product_reg;
  assign bus.valid_out = valid_out_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Self-checking bench for seq_multiplier_param at WIDTH=8 with a product/latency scoreboard.
// Build with SEQ_MUL_EARLY_TERM_EN defined to exercise early termination.
module tb_seq_multiplier_param;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   acc_cyc = 0;

  logic [2*W-1:0] exp_q[$];
  int             lat_q[$];

  seq_multiplier_param_if #(.WIDTH(W)) bus ();

  seq_multiplier_param #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef SEQ_MUL_EARLY_TERM_EN
    int h = 0;
    for (int i = 0; i < W; i++) if (b[i]) h = i + 1;
    return (h < 1) ? 1 : h;
`else
    return (b == b) ? W : 0;
`endif
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic [2*W-1:0] e);
    int t = 0;
    while (bus.ready_in !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (bus.ready_in !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout ready_in=%b required 1", bus.ready_in);
    end
    bus.valid_in     = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.signed_mode  = s;
    exp_q.push_back(e);
    lat_q.push_back(exp_lat(b));
    acc_cyc = cyc + 1;
    @(negedge clk);
    bus.valid_in     = 1'b0;
    // Operands and mode must be latched at accept; scramble them afterwards.
    bus.multiplicand = W'($urandom);
    bus.multiplier   = W'($urandom);
    bus.signed_mode  = ~s;
  endtask

  // Returns at the negedge where valid_out is first seen high.
  task automatic receive(input string name);
    int t = 0;
    logic [2*W-1:0] e;
    int el;
    while (bus.valid_out !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    e  = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    el = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
    checks++;
    if (bus.valid_out !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid_timeout valid_out=%b required 1", name, bus.valid_out);
      return;
    end
    checks++;
    if (bus.product !== e) begin
      errors++;
      $display("FAIL %s_product got %h required %h", name, bus.product, e);
    end
    checks++;
    if (cyc - acc_cyc != el) begin
      errors++;
      $display("FAIL %s_latency got %0d required %0d", name, cyc - acc_cyc, el);
    end
    $display("txn %s product=%h expected=%h latency=%0d", name, bus.product, e, cyc - acc_cyc);
  endtask

  task automatic do_txn(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [2*W-1:0] e);
    send(a, b, s, e);
    receive(name);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.valid_in = 1'b0;
    bus.ready_out = 1'b1;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    bus.signed_mode = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.valid_out !== 1'b0 || bus.product !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b p=%h b=%b required v=0 p=0000 b=0",
               bus.valid_out, bus.product, bus.busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ready_in !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_in got %b required 1", bus.ready_in);
    end
    $display("txn reset ready_in=%b valid_out=%b", bus.ready_in, bus.valid_out);
  endtask

  task automatic test_unsigned();
    do_txn("u255x255", 8'd255, 8'd255, 1'b0, 16'hFE01);
    // do_txn ended one cycle after the handshake edge.
    checks++;
    if (bus.valid_out !== 1'b0 || bus.ready_in !== 1'b1) begin
      errors++;
      $display("FAIL u255_release got v=%b r=%b required v=0 r=1", bus.valid_out, bus.ready_in);
    end
    do_txn("u0x77", 8'd0, 8'd77, 1'b0, 16'h0000);
    do_txn("s77x0", 8'd77, 8'd0, 1'b1, 16'h0000);
  endtask

  task automatic test_signed();
    do_txn("s-3x5", 8'hFD, 8'd5, 1'b1, 16'hFFF1);
    do_txn("s-128x-128", 8'h80, 8'h80, 1'b1, 16'h4000);
    do_txn("s127x-128", 8'h7F, 8'h80, 1'b1, 16'hC080);
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic s;
    for (int i = 0; i < 8; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      s = 1'(i % 2);
      do_txn("rand", a, b, s, model(a, b, s));
    end
  endtask

  task automatic test_backpressure();
    send(8'd12, 8'd10, 1'b0, 16'h0078);
    bus.ready_out = 1'b0;
    receive("bp12x10");
    for (int i = 0; i < 5; i++) begin
      bus.valid_in = 1'b1;
      bus.multiplicand = 8'd99;
      bus.multiplier = 8'd99;
      @(negedge clk);
      checks++;
      if (bus.valid_out !== 1'b1 || bus.product !== 16'h0078 || bus.ready_in !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold got v=%b p=%h r=%b required v=1 p=0078 r=0",
                 bus.valid_out, bus.product, bus.ready_in);
      end
    end
    bus.valid_in = 1'b0;
    bus.ready_out = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.valid_out !== 1'b0 || bus.busy !== 1'b0 || bus.ready_in !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got v=%b b=%b r=%b required v=0 b=0 r=1",
               bus.valid_out, bus.busy, bus.ready_in);
    end
    $display("txn backpressure released valid_out=%b busy=%b", bus.valid_out, bus.busy);
  endtask

  task automatic test_reset_mid_calc();
    logic seen;
    send(8'd200, 8'd3, 1'b0, 16'd600);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.valid_out !== 1'b0 || bus.product !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs got v=%b p=%h b=%b required v=0 p=0000 b=0",
               bus.valid_out, bus.product, bus.busy);
    end
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ready_in !== 1'b1 || bus.product !== '0) begin
      errors++;
      $display("FAIL midreset_release got r=%b p=%h required r=1 p=0000", bus.ready_in, bus.product);
    end
    seen = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      if (bus.valid_out !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midreset_no_emit got valid_out pulse required none");
    end
    $display("txn reset_mid_calc abandoned, ready_in=%b", bus.ready_in);
    do_txn("u7x9", 8'd7, 8'd9, 1'b0, 16'h003F);
  endtask

  task automatic test_back_to_back();
    int n_acc = 0;
    int n_res = 0;
    logic [2*W-1:0] e;
    bus.valid_in = 1'b1;
    bus.multiplicand = 8'd2;
    bus.multiplier = 8'd3;
    bus.signed_mode = 1'b0;
    for (int c = 0; c < 100 && n_res < 2; c++) begin
      if (bus.valid_in && bus.ready_in) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_accept_state busy=%b required 0", bus.busy);
        end
        exp_q.push_back((n_acc == 0) ? 16'd6 : 16'd20);
        lat_q.push_back(W);
        n_acc++;
      end
      if (bus.valid_out === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        void'(lat_q.pop_front());
        checks++;
        if (bus.product !== e) begin
          errors++;
          $display("FAIL b2b_product got %h required %h", bus.product, e);
        end
        $display("txn b2b product=%h expected=%h", bus.product, e);
        n_res++;
      end
      @(negedge clk);
      if (n_acc == 1) begin
        bus.multiplicand = 8'd4;
        bus.multiplier = 8'd5;
      end else if (n_acc == 2) begin
        bus.valid_in = 1'b0;
      end
    end
    bus.valid_in = 1'b0;
    checks++;
    if (n_res != 2) begin
      errors++;
      $display("FAIL b2b_count got %0d results required 2", n_res);
    end
    @(negedge clk);
  endtask

`ifdef SEQ_MUL_EARLY_TERM_EN
  task automatic test_early_term();
    do_txn("et100x1", 8'd100, 8'd1, 1'b0, 16'h0064);
    do_txn("et5x-1", 8'd5, 8'hFF, 1'b1, 16'hFFFB);
    do_txn("et-7x3", 8'hF9, 8'd3, 1'b1, 16'hFFEB);
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
`ifdef SEQ_MUL_EARLY_TERM_EN
    test_early_term();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
